// File: rtl/conv_layer_ctrl_pkg.sv
// Shared constants for the convolution layer controller: layer geometry
// defaults, bus widths and the FSM state encoding.
package conv_layer_ctrl_pkg;

  // Layer geometry defaults (96x96 input map, 88x88 output map)
  localparam int DEF_NUM_IN    = 9216;
  localparam int DEF_NUM_OUT   = 7744;
  localparam int DEF_DRAIN_MAX = 1024;

  // Bus widths
  localparam int PIX_W  = 16;
  localparam int IN_AW  = 14;
  localparam int OUT_AW = 13;
  localparam int CNT_W  = 14;  // one bit wider than OUT_AW so NUM_OUT itself fits
  localparam int ST_W   = 3;

  // FSM state encoding
  localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] ST_FILL  = 3'd1;
  localparam logic [ST_W-1:0] ST_RUN   = 3'd2;
  localparam logic [ST_W-1:0] ST_DRAIN = 3'd3;
  localparam logic [ST_W-1:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/conv_out_writer.sv
// Turns engine result strobes into output-RAM writes and keeps the saturating
// count of results written for the current layer.
module conv_out_writer
  import conv_layer_ctrl_pkg::*;
#(
  parameter int NUM_OUT = DEF_NUM_OUT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,     // start of a new layer
  input  logic              i_active,  // engine is running (RUN or DRAIN)
  input  logic              i_save,
  input  logic [PIX_W-1:0]  i_data,
  output logic              o_we,
  output logic [OUT_AW-1:0] o_addr,
  output logic [PIX_W-1:0]  o_data,
  output logic              o_hit,     // this write is the last one of the layer
  output logic              o_full     // all NUM_OUT results already written
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_OUT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Write strobe and address are combinational so a result lands in the same
  // cycle it is presented; saves beyond NUM_OUT are dropped.
  always_comb begin
    o_full = (r_cnt == FULL_CNT);
    o_we   = i_active && i_save && !o_full;
    o_addr = r_cnt[OUT_AW-1:0];
    o_data = i_data;
    o_hit  = o_we && (r_cnt == LAST_CNT);
  end

  // Result counter: cleared per layer, advances on every accepted write.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_cnt <= '0;
    end else if (o_we) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/conv_layer_ctrl.sv
// Layer sequencer for a streaming conv engine: reads the input map from RAM,
// feeds the engine one pixel per cycle, collects results and signals
// completion or a drain timeout.
//
// Handshakes: go is a one-cycle request taken only in IDLE (no ready; a go
// seen elsewhere is dropped). eng_save is a one-cycle valid with no
// back-pressure: every strobe in RUN/DRAIN below the result limit is written
// to the output RAM in that same cycle.
module conv_layer_ctrl
  import conv_layer_ctrl_pkg::*;
#(
  parameter int NUM_IN    = DEF_NUM_IN,
  parameter int NUM_OUT   = DEF_NUM_OUT,
  parameter int DRAIN_MAX = DEF_DRAIN_MAX
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              go,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              in_rd_en,
  output logic [IN_AW-1:0]  in_addr,
  input  logic [PIX_W-1:0]  in_data,
  output logic [PIX_W-1:0]  map_in,
  output logic              eng_start,
  output logic              eng_clr,
  input  logic              eng_save,
  input  logic [PIX_W-1:0]  eng_map_out,
  output logic              out_we,
  output logic [OUT_AW-1:0] out_addr,
  output logic [PIX_W-1:0]  out_data,
  output logic [ST_W-1:0]   dbg_state
);

  localparam int DW = $clog2(DRAIN_MAX + 1);
  localparam logic [IN_AW-1:0] LAST_ADDR  = IN_AW'(NUM_IN - 1);
  localparam logic [DW-1:0]    DRAIN_LAST = DW'(DRAIN_MAX - 1);

  logic [ST_W-1:0]  r_state;
  logic [ST_W-1:0]  w_next;
  logic             r_fill;
  logic [IN_AW-1:0] r_in_addr;
  logic             r_rd_en;
  logic             r_rd_q;    // in_data is valid this cycle
  logic             r_last1;   // in_data carries the last pixel
  logic             r_last2;   // map_in carries the last pixel
  logic [PIX_W-1:0] r_map;
  logic [DW-1:0]    r_drain;
  logic             r_err;

  logic w_go_ok;
  logic w_active;
  logic w_last_issue;
  logic w_timeout;
  logic w_hit;
  logic w_full;
  logic w_finish;

  conv_out_writer #(
    .NUM_OUT (NUM_OUT)
  ) u_writer (
    .i_clk    (clk_in),
    .i_rst_n  (rst_n),
    .i_clr    (w_go_ok),
    .i_active (w_active),
    .i_save   (eng_save),
    .i_data   (eng_map_out),
    .o_we     (out_we),
    .o_addr   (out_addr),
    .o_data   (out_data),
    .o_hit    (w_hit),
    .o_full   (w_full)
  );

  // Decode conditions used by the FSM and the datapath.
  always_comb begin
    w_go_ok      = (r_state == ST_IDLE) && go;
    w_active     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    w_last_issue = r_rd_en && (r_in_addr == LAST_ADDR);
    w_timeout    = (r_state == ST_DRAIN) && (r_drain == DRAIN_LAST);
    w_finish     = w_hit || w_full;
  end

  // Next-state logic; result completion takes priority over the drain timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (go) w_next = ST_FILL;
      ST_FILL:  if (r_fill) w_next = ST_RUN;
      ST_RUN: begin
        if (w_finish)     w_next = ST_DONE;
        else if (r_last2) w_next = ST_DRAIN;
      end
      ST_DRAIN: if (w_finish || w_timeout) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // State register, two-cycle FILL timer and drain cycle counter.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_fill  <= 1'b0;
      r_drain <= '0;
    end else begin
      r_state <= w_next;
      r_fill  <= (r_state == ST_FILL) && !r_fill;
      r_drain <= (r_state == ST_DRAIN) ? r_drain + DW'(1) : '0;
    end
  end

  // Error flag: raised by a timeout, kept until the next layer is accepted.
  always_ff @(posedge clk_in) begin
    if (!rst_n || w_go_ok) begin
      r_err <= 1'b0;
    end else if (w_timeout && !w_finish) begin
      r_err <= 1'b1;
    end
  end

  // Input address generator: one read per cycle from 0 up to NUM_IN-1, holding
  // the last address rather than wrapping; stops early if the layer finishes.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_rd_en   <= 1'b0;
      r_in_addr <= '0;
    end else if (w_go_ok) begin
      r_rd_en   <= 1'b1;
      r_in_addr <= '0;
    end else if (r_state == ST_IDLE) begin
      r_rd_en   <= 1'b0;
      r_in_addr <= '0;
    end else if (r_rd_en) begin
      if (w_last_issue || (w_next == ST_DONE)) begin
        r_rd_en <= 1'b0;
      end else begin
        r_in_addr <= r_in_addr + IN_AW'(1);
      end
    end
  end

  // Read-data pipeline: track RAM latency and register the pixel into map_in;
  // map_in is forced to zero whenever no fresh pixel is arriving.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      r_rd_q  <= 1'b0;
      r_last1 <= 1'b0;
      r_last2 <= 1'b0;
      r_map   <= '0;
    end else begin
      r_rd_q  <= r_rd_en;
      r_last1 <= w_last_issue;
      r_last2 <= r_last1;
      r_map   <= (r_rd_q && ((r_state == ST_FILL) || (r_state == ST_RUN))) ? in_data : '0;
    end
  end

  // Output decode from the registered state.
  always_comb begin
    busy      = (r_state != ST_IDLE);
    done      = (r_state == ST_DONE);
    err       = r_err;
    in_rd_en  = r_rd_en;
    in_addr   = r_in_addr;
    map_in    = r_map;
    eng_start = w_active;
    eng_clr   = (r_state == ST_IDLE) || (r_state == ST_DONE);
    dbg_state = r_state;
  end

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Directed bench for conv_layer_ctrl with a small layer (16 in, 4 out,
// drain limit 8). Stimulus pushes expectations into queues; a monitor on the
// falling edge pops and compares them as the DUT presents outputs.
module tb_conv_layer_ctrl;
  import conv_layer_ctrl_pkg::*;

  localparam int P_IN  = 16;
  localparam int P_OUT = 4;
  localparam int P_DM  = 8;

  // Signal ids for timed checks
  localparam logic [3:0] S_MAP   = 4'd0;
  localparam logic [3:0] S_START = 4'd1;
  localparam logic [3:0] S_RDEN  = 4'd2;
  localparam logic [3:0] S_ADDR  = 4'd3;
  localparam logic [3:0] S_BUSY  = 4'd4;
  localparam logic [3:0] S_ERR   = 4'd5;
  localparam logic [3:0] S_CLR   = 4'd6;
  localparam logic [3:0] S_WE    = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;
  localparam logic [3:0] S_OADDR = 4'd9;
  localparam logic [3:0] S_STATE = 4'd10;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic              rst_n;
  logic              go;
  logic              busy;
  logic              done;
  logic              err;
  logic              in_rd_en;
  logic [IN_AW-1:0]  in_addr;
  logic [PIX_W-1:0]  in_data = '0;
  logic [PIX_W-1:0]  map_in;
  logic              eng_start;
  logic              eng_clr;
  logic              eng_save;
  logic [PIX_W-1:0]  eng_map_out;
  logic              out_we;
  logic [OUT_AW-1:0] out_addr;
  logic [PIX_W-1:0]  out_data;
  logic [ST_W-1:0]   dbg_state;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Input RAM model: one-cycle read latency, contents addr*3
  always @(posedge clk_in) in_data <= 16'(in_addr) * 16'd3;

  conv_layer_ctrl #(
    .NUM_IN    (P_IN),
    .NUM_OUT   (P_OUT),
    .DRAIN_MAX (P_DM)
  ) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .go          (go),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .in_rd_en    (in_rd_en),
    .in_addr     (in_addr),
    .in_data     (in_data),
    .map_in      (map_in),
    .eng_start   (eng_start),
    .eng_clr     (eng_clr),
    .eng_save    (eng_save),
    .eng_map_out (eng_map_out),
    .out_we      (out_we),
    .out_addr    (out_addr),
    .out_data    (out_data),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [51:0] exp_q[$];       // {cycle, signal id, value}
  logic [28:0] exp_wr_q[$];    // {out_addr, out_data}
  logic [32:0] exp_done_q[$];  // {cycle, err}
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic [3:0] mon_id;

  function automatic logic [15:0] sig_val(logic [3:0] id);
    case (id)
      S_MAP:   return map_in;
      S_START: return 16'(eng_start);
      S_RDEN:  return 16'(in_rd_en);
      S_ADDR:  return 16'(in_addr);
      S_BUSY:  return 16'(busy);
      S_ERR:   return 16'(err);
      S_CLR:   return 16'(eng_clr);
      S_WE:    return 16'(out_we);
      S_DONE:  return 16'(done);
      S_OADDR: return 16'(out_addr);
      S_STATE: return 16'(dbg_state);
      default: return 16'hdead;
    endcase
  endfunction

  function automatic string sig_name(logic [3:0] id);
    case (id)
      S_MAP:   return "map_in";
      S_START: return "eng_start";
      S_RDEN:  return "in_rd_en";
      S_ADDR:  return "in_addr";
      S_BUSY:  return "busy";
      S_ERR:   return "err";
      S_CLR:   return "eng_clr";
      S_WE:    return "out_we";
      S_DONE:  return "done";
      S_OADDR: return "out_addr";
      S_STATE: return "state";
      default: return "unknown";
    endcase
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: timed checks, write events and done events
  always @(negedge clk_in) begin
    if (mon_en) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i][51:20] == cyc) begin
          mon_id = exp_q[i][19:16];
          check(sig_name(mon_id), 32'(sig_val(mon_id)), 32'(exp_q[i][15:0]));
          exp_q.delete(i);
        end
      end
      if (out_we) begin
        if (exp_wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write cyc=%0d addr=%0d data=%0h", cyc, out_addr, out_data);
        end else begin
          check("wr_addr", 32'(out_addr), 32'(exp_wr_q[0][28:16]));
          check("wr_data", 32'(out_data), 32'(exp_wr_q[0][15:0]));
          void'(exp_wr_q.pop_front());
        end
      end
      if (done) begin
        if (exp_done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done cyc=%0d err=%0b", cyc, err);
        end else begin
          check("done_cycle", 32'(cyc), exp_done_q[0][32:1]);
          check("done_err", 32'(err), 32'(exp_done_q[0][0]));
          void'(exp_done_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic goto(int c);
    while (cyc < c) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic push_t(int c, logic [3:0] id, logic [15:0] v);
    exp_q.push_back({32'(c), id, v});
  endtask

  task automatic push_wr(int a, logic [15:0] v);
    exp_wr_q.push_back({13'(a), v});
  endtask

  task automatic push_done(int c, logic e);
    exp_done_q.push_back({32'(c), e});
  endtask

  task automatic do_save(int c, logic [15:0] v);
    goto(c);
    eng_save    = 1'b1;
    eng_map_out = v;
    goto(c + 1);
    eng_save    = 1'b0;
    eng_map_out = '0;
  endtask

  task automatic push_reset(int c);
    push_t(c, S_BUSY, 0);  push_t(c, S_DONE, 0);  push_t(c, S_ERR, 0);
    push_t(c, S_RDEN, 0);  push_t(c, S_START, 0); push_t(c, S_CLR, 1);
    push_t(c, S_WE, 0);    push_t(c, S_MAP, 0);   push_t(c, S_ADDR, 0);
    push_t(c, S_OADDR, 0); push_t(c, S_STATE, 16'(ST_IDLE));
  endtask

  // Start-of-layer expectations relative to the go cycle t0
  task automatic push_common(int t0);
    push_t(t0 + 1, S_RDEN, 1);  push_t(t0 + 1, S_ADDR, 0);
    push_t(t0 + 1, S_BUSY, 1);  push_t(t0 + 1, S_ERR, 0);
    push_t(t0 + 1, S_START, 0);
    push_t(t0 + 2, S_ADDR, 1);  push_t(t0 + 2, S_START, 0);
    push_t(t0 + 3, S_START, 1); push_t(t0 + 3, S_CLR, 0);
  endtask

  task automatic pulse_go(int t0);
    goto(t0);
    go = 1'b1;
    goto(t0 + 1);
    go = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int t0;
  int t1;

  initial begin
    rst_n       = 1'b0;
    go          = 1'b0;
    eng_save    = 1'b0;
    eng_map_out = '0;
    @(posedge clk_in);
    #1;
    goto(3);
    mon_en = 1'b1;
    push_reset(3);
    rst_n = 1'b1;

    // Layer A: full pixel stream, four results in DRAIN, extra save in DONE
    goto(4);
    t0 = cyc;
    push_common(t0);
    for (int k = 0; k < P_IN; k++) push_t(t0 + 3 + k, S_MAP, 16'(3 * k));
    push_t(t0 + 16, S_ADDR, 15); push_t(t0 + 16, S_RDEN, 1);
    push_t(t0 + 17, S_ADDR, 15); push_t(t0 + 17, S_RDEN, 0);
    push_t(t0 + 19, S_MAP, 0);   push_t(t0 + 19, S_START, 1);
    push_t(t0 + 26, S_WE, 0);    push_t(t0 + 26, S_START, 0);
    push_t(t0 + 26, S_CLR, 1);
    push_t(t0 + 27, S_BUSY, 0);  push_t(t0 + 27, S_DONE, 0);
    push_wr(0, 16'h0011); push_wr(1, 16'h0012);
    push_wr(2, 16'h0013); push_wr(3, 16'h0014);
    push_done(t0 + 26, 1'b0);
    pulse_go(t0);
    do_save(t0 + 20, 16'h0011);
    do_save(t0 + 21, 16'h0012);
    do_save(t0 + 23, 16'h0013);
    do_save(t0 + 25, 16'h0014);
    do_save(t0 + 26, 16'h0099);
    goto(t0 + 30);

    // Layer B: only two results -> drain timeout 8 cycles after DRAIN entry
    t0 = cyc;
    push_common(t0);
    push_t(t0 + 2, S_WE, 0);
    push_t(t0 + 26, S_BUSY, 1);  push_t(t0 + 26, S_START, 1);
    push_t(t0 + 26, S_DONE, 0);
    push_t(t0 + 28, S_BUSY, 0);  push_t(t0 + 30, S_ERR, 1);
    push_wr(0, 16'h0021); push_wr(1, 16'h0022);
    push_done(t0 + 27, 1'b1);
    pulse_go(t0);
    do_save(t0 + 2, 16'h0055);
    do_save(t0 + 5, 16'h0021);
    do_save(t0 + 7, 16'h0022);
    goto(t0 + 32);

    // Layer C: go mid-RUN and in the done cycle must not restart
    t0 = cyc;
    push_common(t0);
    push_t(t0 + 9, S_BUSY, 1);   push_t(t0 + 9, S_ADDR, 8);
    push_t(t0 + 25, S_BUSY, 0);  push_t(t0 + 25, S_DONE, 0);
    push_t(t0 + 26, S_BUSY, 0);  push_t(t0 + 26, S_RDEN, 0);
    push_wr(0, 16'h0031); push_wr(1, 16'h0032);
    push_wr(2, 16'h0033); push_wr(3, 16'h0034);
    push_done(t0 + 24, 1'b0);
    pulse_go(t0);
    pulse_go(t0 + 8);
    do_save(t0 + 20, 16'h0031);
    do_save(t0 + 21, 16'h0032);
    do_save(t0 + 22, 16'h0033);
    do_save(t0 + 23, 16'h0034);
    pulse_go(t0 + 24);
    goto(t0 + 30);

    // Layer D: reset mid-RUN, then go on the first cycle after release
    t0 = cyc;
    t1 = t0 + 9;
    push_common(t0);
    push_t(t0 + 3, S_MAP, 0);
    push_reset(t0 + 9);
    push_common(t1);
    push_t(t1 + 3, S_MAP, 0); push_t(t1 + 4, S_MAP, 3); push_t(t1 + 5, S_MAP, 6);
    push_wr(0, 16'h0041); push_wr(1, 16'h0042);
    push_wr(2, 16'h0043); push_wr(3, 16'h0044);
    push_done(t1 + 24, 1'b0);
    pulse_go(t0);
    goto(t0 + 8);
    rst_n = 1'b0;
    goto(t0 + 9);
    rst_n = 1'b1;
    pulse_go(t1);
    do_save(t1 + 20, 16'h0041);
    do_save(t1 + 21, 16'h0042);
    do_save(t1 + 22, 16'h0043);
    do_save(t1 + 23, 16'h0044);
    goto(t1 + 30);

    // ---------------- final report ----------------
    if (exp_q.size() != 0) begin
      errors += exp_q.size();
      $display("FAIL missed_timed_checks count=%0d expected=0", exp_q.size());
    end
    if (exp_wr_q.size() != 0) begin
      errors += exp_wr_q.size();
      $display("FAIL missing_writes count=%0d expected=0", exp_wr_q.size());
    end
    if (exp_done_q.size() != 0) begin
      errors += exp_done_q.size();
      $display("FAIL missing_done count=%0d expected=0", exp_done_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Time limit on the whole run
  initial begin
    #50000;
    $display("FAIL watchdog cyc=%0d limit=5000", cyc);
    $fatal(1, "time limit reached");
  end

endmodule
